io_port_bridge: RTL and testbench

Peripheral-side partner of the CPU's 16-bit I/O port pair. It buffers words written by the CPU's OUT instruction into a FIFO and drains them to an external valid/ready stream. In the other direction, it accepts words from an external valid/ready stream into a holding register that drives the CPU's in_port until the CPU acknowledges the read. It sits at the CPU top level, between the CPU core and the external host or peripheral.

---
 rtl/io_port_bridge.sv | 93 +++++++++
 tb/tb_io_port_bridge.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/io_port_bridge.sv
// CPU-side I/O port bridge: buffers CPU OUT words into a TX FIFO drained over valid/ready,
// and parks one inbound valid/ready word in a holding register until the CPU acknowledges it.
module io_port_bridge #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int AW     = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] cpu_out_port,
   input  logic              cpu_out_we,
   output logic [DATA_W-1:0] cpu_in_port,
   input  logic              cpu_in_ack,
   output logic              in_pending,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [AW:0]       tx_count,
   output logic              ovf_err,
   input  logic              ovf_clr,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic              rx_ready
);

   localparam logic ST_EMPTY = 1'b0;
   localparam logic ST_FULL  = 1'b1;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count;
   logic              full, push, pop;

   logic              in_full;
   logic [DATA_W-1:0] in_data;

   assign full     = (count == DEPTH_C);
   assign tx_valid = (count != '0);
   assign pop      = tx_valid && tx_ready;
   // A pop in the same cycle frees the slot, so a write into a full FIFO still lands.
   assign push     = cpu_out_we && (!full || pop);
   assign tx_data  = mem[rd_ptr];
   assign tx_count = count;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= cpu_out_port;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Set has priority over clear so a drop coinciding with a clear is never lost.
   always_ff @(posedge clk) begin
      if (!rst)                                ovf_err <= 1'b0;
      else if (cpu_out_we && full && !pop)     ovf_err <= 1'b1;
      else if (ovf_clr)                        ovf_err <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         in_full <= ST_EMPTY;
         in_data <= '0;
      end else begin
         case (in_full)
            ST_EMPTY: if (rx_valid) begin
               in_data <= rx_data;
               in_full <= ST_FULL;
            end
            ST_FULL: if (cpu_in_ack) in_full <= ST_EMPTY;
            default: in_full <= ST_EMPTY;
         endcase
      end
   end

   assign cpu_in_port = in_data;
   assign in_pending  = in_full;
   assign rx_ready    = (in_full == ST_EMPTY);

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed bench for io_port_bridge: reset, ordered drain, overflow, full push+pop, wrap, RX handshake.
module tb_io_port_bridge;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 8;
   localparam int AW     = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] cpu_out_port;
   logic              cpu_out_we;
   logic [DATA_W-1:0] cpu_in_port;
   logic              cpu_in_ack;
   logic              in_pending;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [AW:0]       tx_count;
   logic              ovf_err;
   logic              ovf_clr;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;

   int errors = 0;
   int checks = 0;

   io_port_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .cpu_out_port(cpu_out_port), .cpu_out_we(cpu_out_we),
      .cpu_in_port(cpu_in_port), .cpu_in_ack(cpu_in_ack), .in_pending(in_pending),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_count(tx_count),
      .ovf_err(ovf_err), .ovf_clr(ovf_clr),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [DATA_W-1:0] q[$];
      int nxt, rcv, cyc;
      logic pop_m, push_m;

      rst = 1'b0; cpu_out_port = '0; cpu_out_we = 1'b0; cpu_in_ack = 1'b0;
      tx_ready = 1'b0; ovf_clr = 1'b0; rx_data = '0; rx_valid = 1'b0;

      // Reset then idle
      tick(); tick();
      rst = 1'b1;
      tick();
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_count", 32'(tx_count), 32'd0);
      check("rst_rx_ready", 32'(rx_ready), 32'd1);
      check("rst_in_pending", 32'(in_pending), 32'd0);
      check("rst_cpu_in_port", 32'(cpu_in_port), 32'h0000);
      check("rst_ovf_err", 32'(ovf_err), 32'd0);

      // Ordered drain
      cpu_out_we = 1'b1;
      cpu_out_port = 16'h1111; tick();
      check("first_word_latency", 32'(tx_valid), 32'd1);
      cpu_out_port = 16'h2222; tick();
      cpu_out_port = 16'h3333; tick();
      cpu_out_we = 1'b0;
      check("drain_count3", 32'(tx_count), 32'd3);
      check("drain_head", 32'(tx_data), 32'h1111);
      tx_ready = 1'b1;
      tick();
      check("drain_w2", 32'(tx_data), 32'h2222);
      tick();
      check("drain_w3", 32'(tx_data), 32'h3333);
      tick();
      check("drain_empty_valid", 32'(tx_valid), 32'd0);
      check("drain_empty_count", 32'(tx_count), 32'd0);
      tx_ready = 1'b0;

      // Overflow: 9 writes into 8 slots
      cpu_out_we = 1'b1;
      for (int i = 0; i < 9; i++) begin
         cpu_out_port = 16'hA000 + 16'(i);
         tick();
      end
      cpu_out_we = 1'b0;
      check("ovf_count8", 32'(tx_count), 32'd8);
      check("ovf_set", 32'(ovf_err), 32'd1);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("ovf_drain", 32'(tx_data), 32'hA000 + 32'(i));
         tick();
      end
      check("ovf_drain_empty", 32'(tx_valid), 32'd0);
      tx_ready = 1'b0;
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      check("ovf_clr_first", 32'(ovf_err), 32'd0);

      // Refill, then set+clear in the same cycle: set wins
      cpu_out_we = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cpu_out_port = 16'hC000 + 16'(i);
         tick();
      end
      cpu_out_port = 16'hDEAD; ovf_clr = 1'b1;
      tick();
      cpu_out_we = 1'b0;
      check("ovf_set_wins", 32'(ovf_err), 32'd1);
      tick();
      ovf_clr = 1'b0;
      check("ovf_clr_alone", 32'(ovf_err), 32'd0);
      check("ovf_refill_count", 32'(tx_count), 32'd8);

      // Full with simultaneous push and pop
      cpu_out_we = 1'b1; cpu_out_port = 16'hBEEF; tx_ready = 1'b1;
      tick();
      cpu_out_we = 1'b0;
      check("fullpp_count", 32'(tx_count), 32'd8);
      check("fullpp_ovf", 32'(ovf_err), 32'd0);
      for (int i = 1; i < 8; i++) begin
         check("fullpp_drain", 32'(tx_data), 32'hC000 + 32'(i));
         tick();
      end
      check("fullpp_last", 32'(tx_data), 32'hBEEF);
      tick();
      check("fullpp_empty", 32'(tx_valid), 32'd0);
      tx_ready = 1'b0;

      // Pointer wrap with tx_ready toggling; only write when the model says the word fits
      nxt = 0; rcv = 0; cyc = 0;
      while ((nxt < 20 || q.size() != 0) && cyc < 200) begin
         check("wrap_count", 32'(tx_count), 32'(q.size()));
         tx_ready = cyc[0];
         pop_m = (q.size() != 0) && tx_ready;
         if (pop_m) check("wrap_data", 32'(tx_data), 32'(q[0]));
         push_m = (nxt < 20) && (q.size() < DEPTH || pop_m);
         cpu_out_we = push_m;
         cpu_out_port = 16'(nxt);
         tick();
         if (pop_m) begin void'(q.pop_front()); rcv++; end
         if (push_m) begin q.push_back(16'(nxt)); nxt++; end
         cyc++;
      end
      cpu_out_we = 1'b0; tx_ready = 1'b0;
      check("wrap_received", 32'(rcv), 32'd20);
      check("wrap_no_ovf", 32'(ovf_err), 32'd0);

      // RX handshake
      rx_valid = 1'b1; rx_data = 16'h00C3;
      tick();
      check("rx_port_c3", 32'(cpu_in_port), 32'h00C3);
      check("rx_pending", 32'(in_pending), 32'd1);
      check("rx_ready_full", 32'(rx_ready), 32'd0);
      rx_data = 16'h00C4;
      tick();
      check("rx_hold", 32'(cpu_in_port), 32'h00C3);
      cpu_in_ack = 1'b1;
      tick();
      cpu_in_ack = 1'b0;
      check("rx_ack_pending", 32'(in_pending), 32'd0);
      check("rx_ack_retain", 32'(cpu_in_port), 32'h00C3);
      check("rx_ack_ready", 32'(rx_ready), 32'd1);
      tick();
      rx_valid = 1'b0;
      check("rx_port_c4", 32'(cpu_in_port), 32'h00C4);
      check("rx_pending_c4", 32'(in_pending), 32'd1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("rx_rst_pending", 32'(in_pending), 32'd0);
      check("rx_rst_port", 32'(cpu_in_port), 32'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
